// File: rtl/r5p_tcb_arb2_if.sv
// tcb_lite_if: TCB-lite manager/subordinate link with fixed-latency response
interface tcb_lite_if #(
   parameter int unsigned DLY = 1
);
   logic        vld;
   logic        lck;
   logic        ndn;
   logic        wen;
   logic        ren;
   logic [2:0]  ctl;
   logic [31:0] adr;
   logic [1:0]  siz;
   logic [3:0]  byt;
   logic [31:0] wdt;
   logic [31:0] rdt;
   logic        sts;
   logic        rdy;
   logic        trn;
   assign trn = vld & rdy;
   modport man (output vld, lck, ndn, wen, ren, ctl, adr, siz, byt, wdt, input rdt, sts, rdy, trn);
   modport sub (input vld, lck, ndn, wen, ren, ctl, adr, siz, byt, wdt, output rdt, sts, rdy, input trn);
endinterface

// File: rtl/r5p_tcb_arb2.sv
// r5p_tcb_arb2: 2-to-1 TCB-lite arbiter merging IFU and LSU onto one memory port
module r5p_tcb_arb2 #(
   parameter int unsigned DLY = 1,
   parameter bit          RR  = 1'b1,
   parameter bit          DBG = 1'b0
)(
   input  logic       clk,
   input  logic       rst,
   tcb_lite_if.sub    tcb_ifu,
   tcb_lite_if.sub    tcb_lsu,
   tcb_lite_if.man    tcb_mem,
   output logic [1:0] gnt
);
   typedef enum logic [1:0] {UNL, LCK_IFU, LCK_LSU} lck_t;
   lck_t st_q, st_d;
   logic ptr_q, stl_q, sid_q, any, arb, hld, id, rval, rid;
   if (tcb_ifu.DLY != DLY || tcb_lsu.DLY != DLY || tcb_mem.DLY != DLY) begin : g_chk
      $fatal(1, "r5p_tcb_arb2: interface DLY differs from parameter DLY");
   end
   // a stalled transfer keeps its grant as long as its manager still presents it
   always_comb begin
      any  = tcb_ifu.vld | tcb_lsu.vld;
      arb  = (tcb_ifu.vld & tcb_lsu.vld) ? (RR ? ptr_q : 1'b1) : tcb_lsu.vld;
      hld  = stl_q & (sid_q ? tcb_lsu.vld : tcb_ifu.vld);
      id   = (st_q == LCK_IFU) ? 1'b0 : (st_q == LCK_LSU) ? 1'b1 : hld ? sid_q : arb;
      gnt  = (st_q != UNL || any) ? (id ? 2'b10 : 2'b01) : 2'b00;
      st_d = tcb_mem.trn ? (tcb_mem.lck ? (id ? LCK_LSU : LCK_IFU) : UNL) : st_q;
   end
   assign tcb_mem.vld = (st_q == UNL) ? any : (id ? tcb_lsu.vld : tcb_ifu.vld);
   assign tcb_mem.lck = id ? tcb_lsu.lck : tcb_ifu.lck;
   assign tcb_mem.ndn = id ? tcb_lsu.ndn : tcb_ifu.ndn;
   assign tcb_mem.wen = id ? tcb_lsu.wen : tcb_ifu.wen;
   assign tcb_mem.ren = id ? tcb_lsu.ren : tcb_ifu.ren;
   assign tcb_mem.ctl = id ? tcb_lsu.ctl : tcb_ifu.ctl;
   assign tcb_mem.adr = id ? tcb_lsu.adr : tcb_ifu.adr;
   assign tcb_mem.siz = id ? tcb_lsu.siz : tcb_ifu.siz;
   assign tcb_mem.byt = id ? tcb_lsu.byt : tcb_ifu.byt;
   assign tcb_mem.wdt = id ? tcb_lsu.wdt : tcb_ifu.wdt;
   assign tcb_ifu.rdy = gnt[0] & tcb_mem.rdy;
   assign tcb_lsu.rdy = gnt[1] & tcb_mem.rdy;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st_q  <= UNL;
         ptr_q <= 1'b0;
         stl_q <= 1'b0;
         sid_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         stl_q <= tcb_mem.vld & ~tcb_mem.rdy;
         sid_q <= id;
         if (tcb_mem.trn) ptr_q <= ~id;
      end
   if (DLY == 0) begin : g_d0
      assign rval = tcb_mem.trn;
      assign rid  = id;
   end else begin : g_dn
      logic [DLY-1:0] val_q, id_q;
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            val_q <= '0;
            id_q  <= '0;
         end else begin
            val_q[0] <= tcb_mem.trn;
            id_q[0]  <= id;
            for (int i = 1; i < DLY; i++) begin
               val_q[i] <= val_q[i-1];
               id_q[i]  <= id_q[i-1];
            end
         end
      assign rval = val_q[DLY-1];
      assign rid  = id_q[DLY-1];
   end
   assign tcb_ifu.rdt = (rval & ~rid) ? tcb_mem.rdt : '0;
   assign tcb_ifu.sts = (rval & ~rid) ? tcb_mem.sts : 1'b0;
   assign tcb_lsu.rdt = (rval &  rid) ? tcb_mem.rdt : '0;
   assign tcb_lsu.sts = (rval &  rid) ? tcb_mem.sts : 1'b0;
   if (DBG) begin : g_dbg
      a_no_x: assert property (@(posedge clk) disable iff (rst) tcb_mem.vld |-> !$isunknown({tcb_mem.lck, tcb_mem.ndn, tcb_mem.wen, tcb_mem.ren, tcb_mem.ctl, tcb_mem.adr, tcb_mem.siz, tcb_mem.byt, tcb_mem.wdt}));
      a_lck: assert property (@(posedge clk) disable iff (rst) (st_q != UNL && st_d == st_q) |=> $stable(gnt));
   end
endmodule

// File: tb/tb_r5p_tcb_arb2.sv
// tb_r5p_tcb_arb2: directed checks of arbitration, stall, lock, response routing and reset
module tb_r5p_tcb_arb2;
   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] a_gnt, b_gnt, c_gnt;
   logic [31:0] a_q = '0, b_q = '0, c_q1 = '0, c_q2 = '0;
   int n_chk = 0, n_err = 0;
   always #5 clk = ~clk;
   tcb_lite_if #(.DLY(1)) a_ifu(), a_lsu(), a_mem(), b_ifu(), b_lsu(), b_mem();
   tcb_lite_if #(.DLY(2)) c_ifu(), c_lsu(), c_mem();
   r5p_tcb_arb2 #(.DLY(1), .RR(1'b1), .DBG(1'b1)) u_a (.clk(clk), .rst(rst), .tcb_ifu(a_ifu), .tcb_lsu(a_lsu), .tcb_mem(a_mem), .gnt(a_gnt));
   r5p_tcb_arb2 #(.DLY(1), .RR(1'b0), .DBG(1'b1)) u_b (.clk(clk), .rst(rst), .tcb_ifu(b_ifu), .tcb_lsu(b_lsu), .tcb_mem(b_mem), .gnt(b_gnt));
   r5p_tcb_arb2 #(.DLY(2), .RR(1'b1), .DBG(1'b1)) u_c (.clk(clk), .rst(rst), .tcb_ifu(c_ifu), .tcb_lsu(c_lsu), .tcb_mem(c_mem), .gnt(c_gnt));
   // memories answer every transfer with rdt = adr after their latency
   always @(posedge clk) begin
      a_q  <= a_mem.trn ? a_mem.adr : 32'h0;
      b_q  <= b_mem.trn ? b_mem.adr : 32'h0;
      c_q1 <= c_mem.trn ? c_mem.adr : 32'h0;
      c_q2 <= c_q1;
   end
   assign a_mem.rdt = a_q;
   assign b_mem.rdt = b_q;
   assign c_mem.rdt = c_q2;
   assign a_mem.sts = 1'b0;
   assign b_mem.sts = 1'b0;
   assign c_mem.sts = 1'b0;

   task automatic idle();
      a_ifu.vld = 0; a_ifu.lck = 0; a_ifu.ndn = 0; a_ifu.wen = 0; a_ifu.ren = 1; a_ifu.ctl = 0; a_ifu.adr = 0; a_ifu.siz = 2; a_ifu.byt = 4'hf; a_ifu.wdt = 0;
      a_lsu.vld = 0; a_lsu.lck = 0; a_lsu.ndn = 0; a_lsu.wen = 0; a_lsu.ren = 1; a_lsu.ctl = 0; a_lsu.adr = 0; a_lsu.siz = 2; a_lsu.byt = 4'hf; a_lsu.wdt = 0;
      b_ifu.vld = 0; b_ifu.lck = 0; b_ifu.ndn = 0; b_ifu.wen = 0; b_ifu.ren = 1; b_ifu.ctl = 0; b_ifu.adr = 0; b_ifu.siz = 2; b_ifu.byt = 4'hf; b_ifu.wdt = 0;
      b_lsu.vld = 0; b_lsu.lck = 0; b_lsu.ndn = 0; b_lsu.wen = 0; b_lsu.ren = 1; b_lsu.ctl = 0; b_lsu.adr = 0; b_lsu.siz = 2; b_lsu.byt = 4'hf; b_lsu.wdt = 0;
      c_ifu.vld = 0; c_ifu.lck = 0; c_ifu.ndn = 0; c_ifu.wen = 0; c_ifu.ren = 1; c_ifu.ctl = 0; c_ifu.adr = 0; c_ifu.siz = 2; c_ifu.byt = 4'hf; c_ifu.wdt = 0;
      c_lsu.vld = 0; c_lsu.lck = 0; c_lsu.ndn = 0; c_lsu.wen = 0; c_lsu.ren = 1; c_lsu.ctl = 0; c_lsu.adr = 0; c_lsu.siz = 2; c_lsu.byt = 4'hf; c_lsu.wdt = 0;
      a_mem.rdy = 0; b_mem.rdy = 0; c_mem.rdy = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      a_mem.rdy = 1; b_mem.rdy = 1; c_mem.rdy = 1;
      @(negedge clk);
      #1;
      n_chk++; if (a_gnt !== 2'b00) begin n_err++; $display("FAIL reset_a_gnt got %b exp 00", a_gnt); end
      n_chk++; if (b_gnt !== 2'b00) begin n_err++; $display("FAIL reset_b_gnt got %b exp 00", b_gnt); end
      n_chk++; if (c_gnt !== 2'b00) begin n_err++; $display("FAIL reset_c_gnt got %b exp 00", c_gnt); end
      n_chk++; if ({a_ifu.rdy, a_lsu.rdy} !== 2'b00) begin n_err++; $display("FAIL reset_rdy got %b exp 00", {a_ifu.rdy, a_lsu.rdy}); end
      n_chk++; if (a_mem.vld !== 1'b0) begin n_err++; $display("FAIL reset_mem_vld got %b exp 0", a_mem.vld); end
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      n_chk++; if (a_gnt !== 2'b00 || a_mem.vld !== 1'b0) begin n_err++; $display("FAIL idle_a got gnt=%b vld=%b exp 00/0", a_gnt, a_mem.vld); end
      n_chk++; if (a_ifu.rdt !== 32'h0 || a_lsu.rdt !== 32'h0) begin n_err++; $display("FAIL idle_rsp got %h/%h exp 0/0", a_ifu.rdt, a_lsu.rdt); end
   endtask

   task automatic test_round_robin();
      do_reset();
      a_mem.rdy = 1; a_ifu.vld = 1; a_ifu.adr = 32'h40; a_lsu.vld = 1;
      for (int k = 0; k < 7; k++) begin
         if (k == 6) a_lsu.vld = 0;
         a_lsu.adr = 32'h100 + 32'(4 * (k / 2));
         #1;
         n_chk++; if (a_gnt !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_gnt k=%0d got %b", k, a_gnt); end
         n_chk++; if (a_ifu.rdy !== (k % 2 == 0)) begin n_err++; $display("FAIL rr_ifu_rdy k=%0d got %b", k, a_ifu.rdy); end
         n_chk++; if (a_lsu.rdt !== ((k % 2 == 0 && k > 0) ? 32'h100 + 32'(4 * ((k - 1) / 2)) : 32'h0)) begin n_err++; $display("FAIL rr_lsu_rdt k=%0d got %h", k, a_lsu.rdt); end
         n_chk++; if (a_ifu.rdt !== ((k % 2 == 1) ? 32'h40 : 32'h0)) begin n_err++; $display("FAIL rr_ifu_rdt k=%0d got %h", k, a_ifu.rdt); end
         @(negedge clk);
      end
   endtask

   task automatic test_fixed_priority();
      do_reset();
      b_mem.rdy = 1; b_ifu.vld = 1; b_ifu.adr = 32'h40; b_lsu.vld = 1;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) b_lsu.vld = 0;
         b_lsu.adr = 32'h200 + 32'(4 * k);
         #1;
         n_chk++; if (b_gnt !== ((k < 4) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL fp_gnt k=%0d got %b", k, b_gnt); end
         n_chk++; if (b_ifu.rdy !== (k == 4)) begin n_err++; $display("FAIL fp_ifu_rdy k=%0d got %b", k, b_ifu.rdy); end
         n_chk++; if (b_mem.adr !== ((k < 4) ? 32'h200 + 32'(4 * k) : 32'h40)) begin n_err++; $display("FAIL fp_adr k=%0d got %h", k, b_mem.adr); end
         n_chk++; if (b_lsu.rdt !== ((k > 0) ? 32'h200 + 32'(4 * (k - 1)) : 32'h0)) begin n_err++; $display("FAIL fp_lsu_rdt k=%0d got %h", k, b_lsu.rdt); end
         @(negedge clk);
      end
   endtask

   task automatic test_stall();
      // {ifu_vld, lsu_vld, mem_rdy, gnt[1:0], ifu_rdy, lsu_rdy}
      logic [6:0] tbl [9] = '{7'b110_01_00, 7'b110_01_00, 7'b110_01_00, 7'b111_01_10, 7'b111_10_01,
                              7'b010_10_00, 7'b110_10_00, 7'b111_10_01, 7'b110_01_00};
      do_reset();
      for (int k = 0; k < 9; k++) begin
         {a_ifu.vld, a_lsu.vld, a_mem.rdy} = tbl[k][6:4];
         #1;
         n_chk++; if ({a_gnt, a_ifu.rdy, a_lsu.rdy} !== tbl[k][3:0]) begin n_err++; $display("FAIL stall k=%0d got gnt/rdy %b exp %b", k, {a_gnt, a_ifu.rdy, a_lsu.rdy}, tbl[k][3:0]); end
         n_chk++; if (a_mem.vld !== 1'b1) begin n_err++; $display("FAIL stall_vld k=%0d got %b exp 1", k, a_mem.vld); end
         @(negedge clk);
      end
   endtask

   task automatic test_lock();
      // {ifu_vld, lsu_vld, lsu_lck, mem_rdy, gnt[1:0], ifu_rdy, lsu_rdy, mem_vld}
      logic [8:0] tbl [5] = '{9'b0111_10_011, 9'b1001_10_010, 9'b1001_10_010, 9'b1101_10_011, 9'b1100_01_001};
      do_reset();
      a_lsu.adr = 32'h200;
      for (int k = 0; k < 5; k++) begin
         {a_ifu.vld, a_lsu.vld, a_lsu.lck, a_mem.rdy} = tbl[k][8:5];
         #1;
         n_chk++; if ({a_gnt, a_ifu.rdy, a_lsu.rdy, a_mem.vld} !== tbl[k][4:0]) begin n_err++; $display("FAIL lock k=%0d got %b exp %b", k, {a_gnt, a_ifu.rdy, a_lsu.rdy, a_mem.vld}, tbl[k][4:0]); end
         n_chk++; if (a_lsu.rdt !== ((k == 1 || k == 4) ? 32'h200 : 32'h0)) begin n_err++; $display("FAIL lock_rdt k=%0d got %h", k, a_lsu.rdt); end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back_dly2();
      do_reset();
      c_mem.rdy = 1; c_ifu.vld = 1; c_lsu.vld = 1;
      for (int k = 0; k < 8; k++) begin
         if (k == 6) begin c_ifu.vld = 0; c_lsu.vld = 0; end
         c_ifu.adr = 32'h10 + 32'(4 * (k / 2));
         c_lsu.adr = 32'h100 + 32'(4 * (k / 2));
         #1;
         n_chk++; if (c_gnt !== ((k >= 6) ? 2'b00 : (k % 2 == 1) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL d2_gnt k=%0d got %b", k, c_gnt); end
         n_chk++; if (c_ifu.rdt !== ((k >= 2 && k % 2 == 0) ? 32'h10 + 32'(2 * (k - 2)) : 32'h0)) begin n_err++; $display("FAIL d2_ifu_rdt k=%0d got %h", k, c_ifu.rdt); end
         n_chk++; if (c_lsu.rdt !== ((k >= 2 && k % 2 == 1) ? 32'h100 + 32'(4 * ((k - 2) / 2)) : 32'h0)) begin n_err++; $display("FAIL d2_lsu_rdt k=%0d got %h", k, c_lsu.rdt); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      c_mem.rdy = 1; c_ifu.vld = 1; c_ifu.lck = 1; c_ifu.adr = 32'h20;
      #1;
      n_chk++; if (c_gnt !== 2'b01) begin n_err++; $display("FAIL rm_gnt0 got %b exp 01", c_gnt); end
      @(negedge clk);
      c_ifu.adr = 32'h24;
      @(negedge clk);
      idle();
      rst = 1;
      #1;
      n_chk++; if (c_ifu.rdt !== 32'h0 || c_gnt !== 2'b00) begin n_err++; $display("FAIL rm_in_reset got rdt=%h gnt=%b exp 0/00", c_ifu.rdt, c_gnt); end
      @(negedge clk);
      rst = 0;
      #1;
      n_chk++; if (c_ifu.rdt !== 32'h0 || c_lsu.rdt !== 32'h0) begin n_err++; $display("FAIL rm_discard got %h/%h exp 0/0", c_ifu.rdt, c_lsu.rdt); end
      @(negedge clk);
      c_ifu.vld = 1; c_lsu.vld = 1;
      #1;
      n_chk++; if (c_gnt !== 2'b01) begin n_err++; $display("FAIL rm_ptr got %b exp 01", c_gnt); end
      @(negedge clk);
      c_ifu.vld = 0;
      #1;
      n_chk++; if (c_gnt !== 2'b10) begin n_err++; $display("FAIL rm_unlocked got %b exp 10", c_gnt); end
      @(negedge clk);
      idle();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_fixed_priority();
      test_stall();
      test_lock();
      test_back_to_back_dly2();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
